// File: rtl/mem_ctrl.sv
// Single-port word-addressed memory with valid/ready requests, byte-lane writes,
// configurable response latency, post-reset fill sequence and range-error reporting.
module mem_ctrl #(
  parameter int unsigned              DATA_W     = 16,
  parameter int unsigned              ADDR_W     = 16,
  parameter int unsigned              DEPTH      = 1024,
  parameter int unsigned              LATENCY    = 1,
  parameter logic [DATA_W-1:0]        FILL_VALUE = '0
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LANES = DATA_W / 8;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [IW-1:0]       r_init_cnt;
  logic [LW-1:0]       r_lat;
  logic                r_we, r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept, w_oor, w_fire, w_fire_err;
  logic [IW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_rd, w_fire_data;

  assign req_ready = (r_state == S_IDLE);
  assign init_done = (r_state != S_INIT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid && (r_state == S_IDLE);
  // Full-width compare: addresses beyond DEPTH never alias onto low words.
  assign w_oor    = ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH));
  assign w_idx    = req_addr[IW-1:0];
  assign w_rd     = w_oor ? '0 : r_mem[w_idx];

  always_ff @(posedge CLK) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  // A single-cycle latency responds straight from the acceptance edge, so the
  // WAIT state is only visited when LATENCY > 1.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    unique case (r_state)
      S_INIT: if (r_init_cnt == IW'(DEPTH - 1)) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) w_fire = 1'b1;
          else              w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == LW'(1)) begin
          w_fire      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_fire_err  = r_err;
    w_fire_data = (r_we || r_err) ? '0 : r_rdata;
    if (LATENCY == 1) begin
      w_fire_err  = w_oor;
      w_fire_data = (req_we || w_oor) ? '0 : w_rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_init_cnt  <= '0;
      r_lat       <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_fire;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_accept) begin
        r_lat   <= LW'(LATENCY - 1);
        r_we    <= req_we;
        r_err   <= w_oor;
        r_rdata <= w_rd;
      end else if (r_state == S_WAIT) begin
        r_lat <= r_lat - 1'b1;
      end
      if (w_fire) begin
        r_rsp_err   <= w_fire_err;
        r_rsp_rdata <= w_fire_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset_n) begin
      if (r_state == S_INIT) begin
        r_mem[r_init_cnt] <= FILL_VALUE;
      end else if (w_accept && req_we && !w_oor) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (req_be[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl: one instance at LATENCY=1 and one at LATENCY=3.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        rst1_n, rst3_n;

  logic        q1_valid, q1_we, r1_ready, p1_valid, p1_err, d1_done;
  logic [15:0] q1_addr, q1_wdata, p1_rdata;
  logic [1:0]  q1_be;
  logic        q3_valid, q3_we, r3_ready, p3_valid, p3_err, d3_done;
  logic [15:0] q3_addr, q3_wdata, p3_rdata;
  logic [1:0]  q3_be;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(1), .FILL_VALUE(16'h0000)) u1 (
    .CLK(CLK), .reset_n(rst1_n), .req_valid(q1_valid), .req_ready(r1_ready), .req_we(q1_we),
    .req_addr(q1_addr), .req_wdata(q1_wdata), .req_be(q1_be), .rsp_valid(p1_valid),
    .rsp_rdata(p1_rdata), .rsp_err(p1_err), .init_done(d1_done));

  mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(3), .FILL_VALUE(16'h0000)) u3 (
    .CLK(CLK), .reset_n(rst3_n), .req_valid(q3_valid), .req_ready(r3_ready), .req_we(q3_we),
    .req_addr(q3_addr), .req_wdata(q3_wdata), .req_be(q3_be), .rsp_valid(p3_valid),
    .rsp_rdata(p3_rdata), .rsp_err(p3_err), .init_done(d3_done));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance; lat counts edges from the
  // acceptance edge (inclusive) until rsp_valid is seen, 99 on timeout.
  task automatic do_req(input bit s3, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output logic err, output int lat);
    int n;
    if (s3) begin q3_we = we; q3_addr = addr; q3_wdata = wdata; q3_be = be; q3_valid = 1'b1; end
    else    begin q1_we = we; q1_addr = addr; q1_wdata = wdata; q1_be = be; q1_valid = 1'b1; end
    n = 0;
    while (!(s3 ? r3_ready : r1_ready) && n < 50) begin tick(); n++; end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    tick();
    q1_valid = 1'b0;
    q3_valid = 1'b0;
    lat = 1;
    while (!(s3 ? p3_valid : p1_valid) && lat < 20) begin tick(); lat++; end
    if (!(s3 ? p3_valid : p1_valid)) lat = 99;
    rdata = s3 ? p3_rdata : p1_rdata;
    err   = s3 ? p3_err : p1_err;
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, n, cnt_rv, cnt_rdy, nz, cyc, k, j;
    bit          acc;
    int          acc_c [3];
    int          rsp_c [3];
    logic [15:0] rsp_d [3];

    rst1_n = 1'b0; rst3_n = 1'b0;
    q1_valid = 1'b0; q1_we = 1'b0; q1_addr = '0; q1_wdata = '0; q1_be = '0;
    q3_valid = 1'b0; q3_we = 1'b0; q3_addr = '0; q3_wdata = '0; q3_be = '0;
    tick();
    chk("rst_ready", 32'(r1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(p1_valid), 32'd0);
    chk("rst_rdata", 32'(p1_rdata), 32'd0);
    chk("rst_err", 32'(p1_err), 32'd0);
    chk("rst_init_done", 32'(d1_done), 32'd0);
    tick(); tick();

    // Init sequence with a request held pending throughout.
    rst1_n = 1'b1; rst3_n = 1'b1;
    q1_valid = 1'b1; q1_we = 1'b0; q1_addr = 16'd0;
    n = 0; cnt_rv = 0; cnt_rdy = 0;
    while (!d1_done && n < 2000) begin
      tick(); n++;
      if (p1_valid) cnt_rv++;
      if (!d1_done && r1_ready) cnt_rdy++;
    end
    q1_valid = 1'b0;
    chk("init_cycles", 32'(n), 32'd1024);
    chk("init_no_rsp", 32'(cnt_rv), 32'd0);
    chk("init_no_ready", 32'(cnt_rdy), 32'd0);
    chk("init_ready_after", 32'(r1_ready), 32'd1);
    chk("init_done_u3", 32'(d3_done), 32'd1);

    nz = 0;
    for (int a = 0; a < 1024; a++) begin
      do_req(1'b0, 1'b0, 16'(a), 16'h0, 2'b00, rd, er, lat);
      if (rd !== 16'h0 || er !== 1'b0 || lat != 1) nz++;
    end
    chk("fill_all_zero", 32'(nz), 32'd0);

    // Write then immediately read back.
    do_req(1'b0, 1'b1, 16'd30, 16'h0045, 2'b11, rd, er, lat);
    chk("wr30_lat", 32'(lat), 32'd1);
    chk("wr30_rdata", 32'(rd), 32'd0);
    chk("wr30_err", 32'(er), 32'd0);
    do_req(1'b0, 1'b0, 16'd30, 16'h0, 2'b00, rd, er, lat);
    chk("rd30_lat", 32'(lat), 32'd1);
    chk("rd30_rdata", 32'(rd), 32'h45);
    chk("rd30_err", 32'(er), 32'd0);
    tick();
    chk("rsp_pulse_one", 32'(p1_valid), 32'd0);
    tick();
    chk("rdata_hold", 32'(p1_rdata), 32'h45);

    // Byte lanes.
    do_req(1'b0, 1'b1, 16'd5, 16'h1234, 2'b11, rd, er, lat);
    do_req(1'b0, 1'b1, 16'd5, 16'hABCD, 2'b01, rd, er, lat);
    do_req(1'b0, 1'b0, 16'd5, 16'h0, 2'b00, rd, er, lat);
    chk("be01", 32'(rd), 32'h12CD);
    do_req(1'b0, 1'b1, 16'd5, 16'h9999, 2'b00, rd, er, lat);
    chk("be00_lat", 32'(lat), 32'd1);
    chk("be00_err", 32'(er), 32'd0);
    do_req(1'b0, 1'b0, 16'd5, 16'h0, 2'b00, rd, er, lat);
    chk("be00", 32'(rd), 32'h12CD);
    do_req(1'b0, 1'b1, 16'd5, 16'hEF00, 2'b10, rd, er, lat);
    do_req(1'b0, 1'b0, 16'd5, 16'h0, 2'b00, rd, er, lat);
    chk("be10", 32'(rd), 32'hEFCD);

    // Range boundaries.
    do_req(1'b0, 1'b1, 16'd0, 16'h0101, 2'b11, rd, er, lat);
    do_req(1'b0, 1'b1, 16'd1023, 16'h7777, 2'b11, rd, er, lat);
    do_req(1'b0, 1'b0, 16'd1024, 16'h0, 2'b00, rd, er, lat);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_data", 32'(rd), 32'd0);
    do_req(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 2'b11, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1);
    do_req(1'b0, 1'b0, 16'd0, 16'h0, 2'b00, rd, er, lat);
    chk("oor_keep0", 32'(rd), 32'h0101);
    do_req(1'b0, 1'b0, 16'd1023, 16'h0, 2'b00, rd, er, lat);
    chk("oor_keep1023", 32'(rd), 32'h7777);
    chk("last_inrange_err", 32'(er), 32'd0);

    // LATENCY=3 instance.
    do_req(1'b1, 1'b1, 16'd1, 16'h1111, 2'b11, rd, er, lat);
    chk("l3_wr_lat", 32'(lat), 32'd3);
    do_req(1'b1, 1'b1, 16'd2, 16'h2222, 2'b11, rd, er, lat);
    do_req(1'b1, 1'b1, 16'd3, 16'h3333, 2'b11, rd, er, lat);

    for (int i = 0; i < 3; i++) begin acc_c[i] = 0; rsp_c[i] = 0; rsp_d[i] = '0; end
    q3_we = 1'b0; q3_addr = 16'd1; q3_valid = 1'b1;
    cyc = 0; k = 0; j = 0;
    while (j < 3 && cyc < 40) begin
      acc = q3_valid && r3_ready;
      tick(); cyc++;
      if (acc) begin
        acc_c[k] = cyc; k++; q3_addr = q3_addr + 16'd1;
        if (k == 3) q3_valid = 1'b0;
      end
      if (p3_valid) begin rsp_c[j] = cyc; rsp_d[j] = p3_rdata; j++; end
    end
    q3_valid = 1'b0;
    chk("b2b_rsp_count", 32'(j), 32'd3);
    chk("b2b_gap01", 32'(acc_c[1] - acc_c[0]), 32'd3);
    chk("b2b_gap12", 32'(acc_c[2] - acc_c[1]), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_lat", 32'(rsp_c[i] - acc_c[i] + 1), 32'd3);
      chk("b2b_data", 32'(rsp_d[i]), 32'h1111 * 32'(i + 1));
    end

    // Reset while a read is waiting.
    do_req(1'b1, 1'b1, 16'd7, 16'h5A5A, 2'b11, rd, er, lat);
    q3_we = 1'b0; q3_addr = 16'd7; q3_valid = 1'b1;
    tick();
    q3_valid = 1'b0;
    chk("mid_ready_wait", 32'(r3_ready), 32'd0);
    tick();
    chk("mid_no_rsp_yet", 32'(p3_valid), 32'd0);
    rst3_n = 1'b0;
    tick();
    rst3_n = 1'b1;
    chk("mid_rst_done", 32'(d3_done), 32'd0);
    chk("mid_rst_rsp", 32'(p3_valid), 32'd0);
    n = 0; cnt_rv = 0;
    while (!d3_done && n < 2000) begin
      tick(); n++;
      if (p3_valid) cnt_rv++;
    end
    chk("mid_init_cycles", 32'(n), 32'd1024);
    chk("mid_no_rsp", 32'(cnt_rv), 32'd0);
    do_req(1'b1, 1'b0, 16'd7, 16'h0, 2'b00, rd, er, lat);
    chk("mid_refilled", 32'(rd), 32'd0);
    chk("mid_refill_lat", 32'(lat), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
